// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite shared definitions: transfer type / size / response encodings and the
// slave FSM state type used by ahb3lite_sram_slave.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } slv_state_e;

endpackage

// File: rtl/ahb3lite_byte_lane_dec.sv
// Byte-enable decoder for a 32-bit little-endian data bus.
// Ports:
//   hsize_i - transfer size (BYTE/HWORD/WORD); larger sizes give no lanes
//   addr_i  - byte offset within the word (HADDR[1:0])
//   be_o    - per-lane write enable, bit n covers data[8n+7:8n]
module ahb3lite_byte_lane_dec
  import ahb3lite_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] be_o
);

  always_comb begin
    be_o = 4'b0000;
    case (hsize_i)
      HSIZE_BYTE:  be_o = 4'b0001 << addr_i;
      HSIZE_HWORD: be_o = addr_i[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD:  be_o = 4'b1111;
      default:     be_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder: word-organised memory with byte-lane writes, a fixed
// number of wait states per OKAY data phase and a two-cycle ERROR response.
// Optional feature (macro AHB3LITE_SLV_PROT_CHECK_EN): user-mode writes (HPROT[1]=0)
// to the upper half of memory are answered with ERROR and dropped.
// Ports:
//   HCLK, HRESETn          - clock, asynchronous active-low reset
//   HSEL, HADDR, HWRITE,
//   HSIZE, HBURST, HPROT,
//   HTRANS, HREADY         - address-phase inputs (HBURST not interpreted)
//   HWDATA                 - write data (data phase)
//   HRDATA, HREADYOUT,
//   HRESP                  - data-phase outputs
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int unsigned HADDR_SIZE  = 32,
  parameter int unsigned HDATA_SIZE  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned AW       = $clog2(MEM_DEPTH);
  localparam logic [2:0]  LastWait = 3'(WAIT_STATES - 1);

  slv_state_e      state_q, state_d;
  logic [2:0]      wait_cnt_q, wait_cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [2:0]      size_q, size_d;

  logic [HDATA_SIZE-1:0] mem_q [MEM_DEPTH];

  logic            accept;
  logic            ap_err;
  logic [AW-1:0]   word_idx;
  logic [3:0]      be;

  // HBURST is accepted but never interpreted; HPROT only matters with the prot check.
  logic unused_in;
  assign unused_in = ^{HBURST, HPROT};

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign word_idx = addr_q[AW+1:2];

  // Error decision made on the live address phase.
  always_comb begin
    ap_err = 1'b0;
    if (HSIZE > HSIZE_WORD) ap_err = 1'b1;
    if (HSIZE == HSIZE_HWORD && HADDR[0]) ap_err = 1'b1;
    if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) ap_err = 1'b1;
    if (HADDR[HADDR_SIZE-1:AW+2] != '0) ap_err = 1'b1;
`ifdef AHB3LITE_SLV_PROT_CHECK_EN
    // Upper half of memory is word index MSB set.
    if (HWRITE && !HPROT[1] && HADDR[AW+1]) ap_err = 1'b1;
`endif
  end

  ahb3lite_byte_lane_dec u_lane_dec (
    .hsize_i (size_q),
    .addr_i  (addr_q[1:0]),
    .be_o    (be)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    case (state_q)
      // HREADYOUT is high in these states, so a new address phase may be taken.
      StIdle, StData, StErr2: begin
        if (accept) begin
          addr_d     = HADDR[AW+1:0];
          write_d    = HWRITE;
          size_d     = HSIZE;
          wait_cnt_d = 3'd0;
          if (ap_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES != 0) begin
            state_d = StWait;
          end else begin
            state_d = StData;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (wait_cnt_q == LastWait) begin
          state_d = StData;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      wait_cnt_q <= 3'd0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
    end
  end

  // Write commits on the edge that ends the DATA cycle. A reset pulls state_q out of
  // StData asynchronously, so an in-flight write never lands.
  always_ff @(posedge HCLK) begin
    if (state_q == StData && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (state_q)
      StWait: HREADYOUT = 1'b0;
      StData: if (!write_q) HRDATA = mem_q[word_idx];
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      StErr2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: one instance with no wait states (dut0)
// and one with three (dut3). Each slave's HREADY is its own HREADYOUT.
module tb_ahb3lite_sram_slave;
  import ahb3lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hsel0, hsel3;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, resp0, resp3;

  int n_checks = 0;
  int n_fail   = 0;
  int waits;

  always #5 clk = ~clk;

  ahb3lite_sram_slave #(.WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(ready0), .HREADYOUT(ready0), .HRESP(resp0)
  );

  ahb3lite_sram_slave #(.WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel3), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(ready3), .HREADYOUT(ready3), .HRESP(resp3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // {HREADYOUT, HRESP} of each instance
  task automatic chk_rr0(input string tag, input logic [1:0] exp);
    check(tag, {30'b0, ready0, resp0}, {30'b0, exp});
  endtask

  task automatic chk_rr3(input string tag, input logic [1:0] exp);
    check(tag, {30'b0, ready3, resp3}, {30'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ap(input logic s0, input logic s3, input logic [31:0] a, input logic w,
                    input logic [2:0] sz, input logic [1:0] tr, input logic [3:0] pr);
    hsel0  = s0;
    hsel3  = s3;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = tr;
    hprot  = pr;
  endtask

  task automatic idle();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    hwrite = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  // Counts HREADYOUT-low cycles of dut3, bounded; ends on the negedge of the ready cycle.
  task automatic wait3(output int n);
    n = 0;
    @(negedge clk);
    while (ready3 !== 1'b1 && n < 16) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Address phase already driven on dut0; walks the two ERROR cycles.
  task automatic err0(input string tag);
    tick();
    idle();
    smp();
    chk_rr0({tag, "_err1"}, 2'b01);
    check({tag, "_err1_rdata"}, rdata0, 32'h0);
    tick();
    smp();
    chk_rr0({tag, "_err2"}, 2'b11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b1;
    haddr  = '0;
    hwdata = '0;
    hsize  = HSIZE_WORD;
    hburst = 3'b000;
    hprot  = 4'b0011;
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("reset_rdata0", rdata0, 32'h0);
    chk_rr0("reset_rr0", 2'b10);
    chk_rr3("reset_rr3", 2'b10);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Word write then pipelined read of the same word, zero wait.
    ap(1, 0, 32'h10, 1, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    hwdata = 32'hDEADBEEF;
    ap(1, 0, 32'h10, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    smp();
    chk_rr0("wr_dp", 2'b10);
    tick();
    idle();
    hwdata = '0;
    smp();
    check("rd_data", rdata0, 32'hDEADBEEF);
    chk_rr0("rd_dp", 2'b10);
    tick();
    smp();
    check("idle_rdata", rdata0, 32'h0);

    // Byte lane merge.
    tick();
    ap(1, 0, 32'h20, 1, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    hwdata = 32'h11223344;
    ap(1, 0, 32'h22, 1, HSIZE_BYTE, HTRANS_NONSEQ, 4'b0011);
    tick();
    hwdata = 32'h00AA0000;
    ap(1, 0, 32'h20, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    idle();
    smp();
    check("byte_merge", rdata0, 32'h11AA3344);

    // Upper halfword merge.
    tick();
    ap(1, 0, 32'h12, 1, HSIZE_HWORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    hwdata = 32'h55660000;
    ap(1, 0, 32'h10, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    idle();
    smp();
    check("hword_merge", rdata0, 32'h5566BEEF);

    // Error responses.
    tick();
    ap(1, 0, 32'h402, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    err0("misalign_rd");
    tick();
    ap(1, 0, 32'h400, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    err0("range_rd");
    tick();
    hwdata = 32'hFFFFFFFF;
    ap(1, 0, 32'h11, 1, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    err0("misalign_wr");
    tick();
    ap(1, 0, 32'h10, 1, 3'b011, HTRANS_NONSEQ, 4'b0011);
    err0("size_wr");

    // IDLE, BUSY and unselected NONSEQ: OKAY, zero wait, no write.
    tick();
    ap(1, 0, 32'h10, 1, HSIZE_WORD, HTRANS_IDLE, 4'b0011);
    tick();
    smp();
    chk_rr0("idle_okay", 2'b10);
    tick();
    ap(1, 0, 32'h10, 1, HSIZE_WORD, HTRANS_BUSY, 4'b0011);
    tick();
    smp();
    chk_rr0("busy_okay", 2'b10);
    tick();
    ap(0, 0, 32'h10, 1, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    smp();
    chk_rr0("unsel_okay", 2'b10);

    // Back-to-back reads (NONSEQ then SEQ) also confirm memory untouched.
    tick();
    hwdata = '0;
    ap(1, 0, 32'h10, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    ap(1, 0, 32'h20, 0, HSIZE_WORD, HTRANS_SEQ, 4'b0011);
    smp();
    check("b2b_rd0", rdata0, 32'h5566BEEF);
    tick();
    idle();
    smp();
    check("b2b_rd1", rdata0, 32'h11AA3344);

    // Three wait states: pipelined write then read.
    tick();
    ap(0, 1, 32'h10, 1, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    hwdata = 32'hCAFEF00D;
    ap(0, 1, 32'h10, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    wait3(waits);
    check("ws_wr_waits", waits, 32'd3);
    chk_rr3("ws_wr_dp", 2'b10);
    tick();
    idle();
    wait3(waits);
    check("ws_rd_waits", waits, 32'd3);
    check("ws_rd_data", rdata3, 32'hCAFEF00D);

    // Reset during a waited write: outputs recover at once, write is dropped.
    tick();
    ap(0, 1, 32'h10, 1, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    hwdata = 32'hBAD0BAD0;
    idle();
    smp();
    chk_rr3("ws_wait_low", 2'b00);
    #1 rst_n = 1'b0;
    #1;
    chk_rr3("rst_async", 2'b10);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ap(0, 1, 32'h10, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    idle();
    wait3(waits);
    check("rst_drop", rdata3, 32'hCAFEF00D);

    // HPROT handling on the upper half of memory.
    tick();
    ap(1, 0, 32'h300, 1, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    hwdata = 32'h12345678;
    ap(1, 0, 32'h300, 1, HSIZE_BYTE, HTRANS_NONSEQ, 4'b0001);
    smp();
    chk_rr0("prot_init_wr", 2'b10);
    tick();
    hwdata = 32'h00000055;
    idle();
    smp();
`ifdef AHB3LITE_SLV_PROT_CHECK_EN
    chk_rr0("prot_user_err1", 2'b01);
    tick();
    smp();
    chk_rr0("prot_user_err2", 2'b11);
    tick();
    ap(1, 0, 32'h300, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    idle();
    smp();
    check("prot_user_kept", rdata0, 32'h12345678);
    tick();
    ap(1, 0, 32'h300, 1, HSIZE_BYTE, HTRANS_NONSEQ, 4'b0011);
    tick();
    idle();
    smp();
    chk_rr0("prot_priv_okay", 2'b10);
`else
    chk_rr0("prot_ignored_okay", 2'b10);
`endif
    tick();
    ap(1, 0, 32'h300, 0, HSIZE_WORD, HTRANS_NONSEQ, 4'b0011);
    tick();
    idle();
    smp();
    check("prot_final_rd", rdata0, 32'h12345655);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
AHB3-Lite responder: the slave end of the team's AHB3-Lite bus, i.e. the DUT side that a driver clocking block stimulates. It is a word-organised SRAM with byte-lane writes, programmable wait states and a two-cycle ERROR response. It serves as the reference target for the bus agent and as a reusable on-chip memory slave.

Parameters:
HADDR_SIZE, 32, address bus width
HDATA_SIZE, 32, data bus width (fixed at 32 in this revision)
MEM_DEPTH, 256, number of HDATA_SIZE words (power of 2)
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..7)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  reset, asynchronous, active-low
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  byte address
HWDATA  in  HDATA_SIZE  write data (data phase)
HRDATA  out  HDATA_SIZE  read data (data phase)
HWRITE  in  1  1=write, 0=read
HSIZE  in  3  transfer size
HBURST  in  3  burst type (accepted, not interpreted)
HPROT  in  4  protection (used only by the optional feature)
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HREADY  in  1  bus ready (previous transfer complete)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Clock is HCLK. Reset is HRESETn, asynchronous assert, active-low. Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, all address-phase registers 0. Memory contents are not reset.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register HADDR, HWRITE, HSIZE and the error decision.
- IDLE/BUSY (HTRANS[1]=0), or HSEL=0 with HREADY=1: next cycle gives an OKAY, zero-wait response.
- Error decision, evaluated at the address phase. An access is an error if any of these hold:
  - HSIZE > 3'b010;
  - misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0;
  - HADDR >= MEM_DEPTH*4.
- FSM states:
  - IDLE → WAIT when an OKAY access is accepted and WAIT_STATES>0.
  - IDLE → DATA when an OKAY access is accepted and WAIT_STATES=0.
  - IDLE → ERR1 when an error access is accepted.
  - WAIT: HREADYOUT=0, HRESP=0; counts WAIT_STATES cycles, then → DATA.
  - DATA: HREADYOUT=1, HRESP=0; completes the transfer. Goes to IDLE, or straight to WAIT/DATA/ERR1 if a new address phase is accepted in the same cycle (pipelined back-to-back).
  - ERR1: HREADYOUT=0, HRESP=1; always → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; → IDLE, or to a new accepted transfer. Error accesses never modify memory.
- Write: commits at the HCLK edge ending the DATA cycle, using byte enables decoded from the registered HSIZE/HADDR[1:0]. Lane placement is little-endian (byte n on HWDATA[8n+7:8n]).
- Read: in the DATA cycle, HRDATA = mem[registered word index], full word; the master selects lanes. HRDATA=0 in every other state.
- Read directly after a write to the same word returns the new data. No hazard exists, because the write commits before the read's data phase.
- Back-to-back NONSEQ/SEQ with WAIT_STATES=0 sustain one transfer per cycle.
- HRESETn asserted mid-transfer: the in-flight write is dropped and outputs return to reset values immediately.

Optional Feature:
- Macro: AHB3LITE_SLV_PROT_CHECK_EN.
- Defined: a write with HPROT[1]=0 (user) to the upper half of memory (word index >= MEM_DEPTH/2) gets the two-cycle ERROR response and memory is unchanged. Reads are unaffected.
- Undefined: HPROT is ignored entirely.

Decomposition:
- Package ahb3lite_pkg holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11;
  - HSIZE encodings: BYTE=3'b000, HWORD=3'b001, WORD=3'b010;
  - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1;
  - the slave FSM state enum.
- Sub-module ahb3lite_byte_lane_dec maps (HSIZE, HADDR[1:0]) to a 4-bit byte enable (pure combinational).

Test Plan:
- Reset, then write WORD 0xDEADBEEF to 0x10 and read 0x10 (WAIT_STATES=0) → read data phase returns HRDATA=0xDEADBEEF, HREADYOUT=1, HRESP=0, no wait cycles.
- Word at 0x20 = 0x11223344; write BYTE 0xAA to 0x22 (HWDATA[23:16]=0xAA), then read 0x20 → 0x11AA3344.
- WAIT_STATES=3, read 0x10 → HREADYOUT low for exactly 3 cycles, then high with data; back-to-back NONSEQ pipelines correctly.
- WORD read of 0x402 (misaligned) and of 0x400 (out of range, MEM_DEPTH=256) → each gives {HREADYOUT=0,HRESP=1} then {HREADYOUT=1,HRESP=1}; memory unchanged.
- IDLE and BUSY with HSEL=1, and NONSEQ with HSEL=0 → OKAY, zero wait, no memory change.
- With AHB3LITE_SLV_PROT_CHECK_EN: write 0x55 with HPROT=4'b0001 to 0x300 → ERROR, then a read of 0x300 returns the old value; the same write with HPROT=4'b0011 → OKAY and the read returns 0x55.
